fpu_param: RTL and testbench

Parameterised successor to the byte-wide memory-mapped floating-point unit. It sits on the MiniS08 8-bit peripheral bus behind a chip-select and accepts Y and X operands a byte at a time. It runs iterative divide (Y/X) or multiply (Y*X) in a configurable IEEE-style format, with round-to-nearest-even, and exposes status and result registers. Over the previous unit it adds:
- generic exponent and fraction widths
- a fixed, documented latency
- abort and clear-flags commands
- done and exception status bits

---
 rtl/fpu_param_if.sv | 13 +
 rtl/fpu_param.sv | 219 +++++++++++++++++++++
 tb/tb_fpu_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_param_if.sv
// fpu_param_if: MiniS08 8-bit peripheral bus slice seen by the FPU (chip select,
// strobes, 2-bit register address, byte data in/out).
interface fpu_param_if;
  logic       FPUsel;
  logic       read;
  logic       write;
  logic [1:0] addr;
  logic [7:0] datain;
  logic [7:0] dataout;

  modport master (output FPUsel, read, write, addr, datain, input dataout);
  modport slave  (input FPUsel, read, write, addr, datain, output dataout);
endinterface

// File: rtl/fpu_param.sv
// fpu_param: byte-wide memory-mapped iterative FP divide/multiply with generic format and RNE.
// Define FPU_EXCEPT_EN for zero/infinity decode and div-by-zero/overflow/underflow flags.
module fpu_param #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input logic        clk,
  input logic        rst_n,
  fpu_param_if.slave bus
);
  localparam int unsigned W   = 1 + EXP_W + FRAC_W;
  localparam int unsigned NB  = (W + 7) / 8;
  localparam int unsigned VW  = NB * 8;
  localparam int unsigned PAD = VW - W;
  localparam int unsigned MW  = FRAC_W + 1;
  localparam int unsigned PW  = 2 * MW;
  localparam int unsigned XW  = EXP_W + 2;
  localparam int unsigned IW  = $clog2(NB + 1);
  localparam int unsigned CW  = $clog2(FRAC_W + 3);
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL, S_NORM, S_RND} state_t;
  state_t state_q, state_d;

  logic cmd_wr, val_wr, res_rd, stat_rd, cmd_q, val_q, rd_q;
  logic cmd_go, do_start, do_abort, do_clear, do_sel, busy;
  logic [VW-1:0] y_q, x_q, res_q, op_nxt;
  logic [W-1:0] y_w, x_w, res_w;
  logic [EXP_W-1:0] ey, ex;
  logic [MW-1:0] my, mx, mx_q;
  logic sel_x_q, done_q, op_div_q, sign_q, stk_q, ge, rup;
  logic [IW-1:0] in_idx_q, out_idx_q;
  logic [2:0] flags_q, flag_w;
  logic [XW-1:0] exp_q, exp_r;
  logic [PW-1:0] work_q, acc_q;
  logic [CW-1:0] cnt_q;
  logic [MW:0] mant_q, rsum;
  logic [FRAC_W-1:0] frac_r;
  logic [7:0] rd_byte;
`ifdef FPU_EXCEPT_EN
  logic inf_q, zero_q, dz_q;
`endif

  assign cmd_wr  = bus.FPUsel & bus.write & (bus.addr == 2'b10);
  assign val_wr  = bus.FPUsel & bus.write & (bus.addr == 2'b11);
  assign res_rd  = bus.FPUsel & bus.read  & (bus.addr == 2'b01);
  assign stat_rd = bus.FPUsel & bus.read  & (bus.addr == 2'b00);
  assign busy    = (state_q != S_IDLE);

  assign cmd_go   = cmd_wr & ~cmd_q;
  assign do_start = cmd_go & ~busy & ((bus.datain == 8'd3) | (bus.datain == 8'd4));
  assign do_sel   = cmd_go & ~busy & ((bus.datain == 8'd1) | (bus.datain == 8'd2));
  assign do_abort = cmd_go & busy & (bus.datain == 8'd5);
  assign do_clear = cmd_go & (bus.datain == 8'd6);

  assign y_w = W'(y_q >> PAD);
  assign x_w = W'(x_q >> PAD);
  assign ey  = y_w[W-2 -: EXP_W];
  assign ex  = x_w[W-2 -: EXP_W];
  assign my  = {1'b1, y_w[FRAC_W-1:0]};
  assign mx  = {1'b1, x_w[FRAC_W-1:0]};

  assign ge     = (work_q >= PW'(mx_q));
  assign rup    = mant_q[0] & (stk_q | mant_q[1]);
  assign rsum   = {1'b0, mant_q[MW:1]} + (MW + 1)'(rup);
  assign exp_r  = exp_q + XW'(rsum[MW]);
  assign frac_r = rsum[MW] ? '0 : rsum[FRAC_W-1:0];

  always_comb begin
    op_nxt = sel_x_q ? x_q : y_q;
    for (int unsigned k = 0; k < NB; k++) begin
      if (in_idx_q == IW'(k)) begin
        if (k == 0) op_nxt = '0;
        op_nxt[VW-1-8*k -: 8] = bus.datain;
      end
    end
  end

  // Exponent kept in two's complement; the sign bit flags underflow below zero.
  always_comb begin
    res_w  = {sign_q, exp_r[EXP_W-1:0], frac_r};
    flag_w = '0;
`ifdef FPU_EXCEPT_EN
    if (inf_q) begin
      res_w     = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flag_w[2] = dz_q;
    end else if (zero_q) begin
      res_w = {sign_q, {(W-1){1'b0}}};
    end else if (!exp_r[XW-1] && (exp_r >= EMAX)) begin
      res_w     = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flag_w[1] = 1'b1;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      res_w     = {sign_q, {(W-1){1'b0}}};
      flag_w[0] = 1'b1;
    end
`endif
  end

  always_comb begin
    rd_byte = '0;
    for (int unsigned k = 0; k < NB; k++)
      if (out_idx_q == IW'(k)) rd_byte = res_q[VW-1-8*k -: 8];
    bus.dataout = '0;
    if (stat_rd)     bus.dataout = {busy, done_q, flags_q, 3'b000};
    else if (res_rd) bus.dataout = rd_byte;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (do_start) state_d = (bus.datain == 8'd3) ? S_DIV : S_MUL;
      S_DIV, S_MUL: if (cnt_q == CW'(FRAC_W + 1)) state_d = S_NORM;
      S_NORM:       state_d = S_RND;
      S_RND:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (do_abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= 1'b0; val_q <= 1'b0; rd_q <= 1'b0;
      y_q <= '0; x_q <= '0; res_q <= '0;
      sel_x_q <= 1'b0; in_idx_q <= '0; out_idx_q <= '0;
      done_q <= 1'b0; flags_q <= '0;
      op_div_q <= 1'b0; sign_q <= 1'b0; exp_q <= '0;
      work_q <= '0; acc_q <= '0; mx_q <= '0; cnt_q <= '0;
      mant_q <= '0; stk_q <= 1'b0;
`ifdef FPU_EXCEPT_EN
      inf_q <= 1'b0; zero_q <= 1'b0; dz_q <= 1'b0;
`endif
    end else begin
      cmd_q <= cmd_wr;
      val_q <= val_wr;
      rd_q  <= res_rd;

      if (val_wr && (in_idx_q < IW'(NB))) begin
        if (sel_x_q) x_q <= op_nxt;
        else         y_q <= op_nxt;
      end
      if (val_q && !val_wr && (in_idx_q < IW'(NB))) in_idx_q <= in_idx_q + IW'(1);
      if (do_sel) begin
        sel_x_q  <= (bus.datain == 8'd2);
        in_idx_q <= '0;
      end
      if (rd_q && !res_rd)
        out_idx_q <= (out_idx_q == IW'(NB - 1)) ? '0 : out_idx_q + IW'(1);
      if (do_clear) begin
        done_q  <= 1'b0;
        flags_q <= '0;
      end

      case (state_q)
        S_IDLE: if (do_start) begin
          op_div_q <= (bus.datain == 8'd3);
          sign_q   <= y_w[W-1] ^ x_w[W-1];
          exp_q    <= (bus.datain == 8'd3) ? {2'b00, ey} - {2'b00, ex} + BIAS
                                           : {2'b00, ey} + {2'b00, ex} - BIAS;
          work_q   <= PW'(my);
          mx_q     <= mx;
          acc_q    <= '0;
          cnt_q    <= '0;
          done_q   <= 1'b0;
`ifdef FPU_EXCEPT_EN
          inf_q  <= (bus.datain == 8'd3) && (ex == '0);
          dz_q   <= (bus.datain == 8'd3) && (ex == '0);
          zero_q <= (bus.datain == 8'd3) ? ((ey == '0) && (ex != '0)) : ((ey == '0) || (ex == '0));
`endif
        end
        S_DIV: begin
          acc_q  <= {acc_q[PW-2:0], ge};
          work_q <= (ge ? work_q - PW'(mx_q) : work_q) << 1;
          cnt_q  <= cnt_q + CW'(1);
        end
        // Multiplier drains to zero after FRAC_W+1 shifts, so the pad cycle adds nothing.
        S_MUL: begin
          if (mx_q[0]) acc_q <= acc_q + work_q;
          work_q <= work_q << 1;
          mx_q   <= mx_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
        end
        // Divide: when the integer quotient bit is 0 the guard is the next quotient bit,
        // taken from the final remainder rather than another iteration.
        S_NORM: begin
          if (op_div_q) begin
            if (acc_q[MW]) begin
              mant_q <= acc_q[MW:0];
              stk_q  <= |work_q;
            end else begin
              mant_q <= {acc_q[MW-1:0], ge};
              stk_q  <= ge ? (work_q != PW'(mx_q)) : (|work_q);
              exp_q  <= exp_q - XW'(1);
            end
          end else if (acc_q[PW-1]) begin
            mant_q <= acc_q[PW-1 -: MW+1];
            stk_q  <= |acc_q[PW-MW-2:0];
            exp_q  <= exp_q + XW'(1);
          end else begin
            mant_q <= acc_q[PW-2 -: MW+1];
            stk_q  <= |acc_q[PW-MW-3:0];
          end
        end
        S_RND: if (!do_abort) begin
          res_q     <= VW'(res_w) << PAD;
          done_q    <= 1'b1;
          flags_q   <= (do_clear ? 3'b000 : flags_q) | flag_w;
          out_idx_q <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_param.sv
// tb_fpu_param: directed bus-level checks of fpu_param in the default format and in a
// 16-bit (EXP_W=5, FRAC_W=10) format; expectations follow FPU_EXCEPT_EN when defined.
module tb_fpu_param;
  logic       clk, rst_n;
  logic       cs, rd, wr, use_b;
  logic [1:0] ad;
  logic [7:0] din, rdata;
  int unsigned checks, errors;

  fpu_param_if bus_a ();
  fpu_param_if bus_b ();

  assign bus_a.FPUsel = cs & ~use_b;
  assign bus_b.FPUsel = cs & use_b;
  assign bus_a.read   = rd;
  assign bus_b.read   = rd;
  assign bus_a.write  = wr;
  assign bus_b.write  = wr;
  assign bus_a.addr   = ad;
  assign bus_b.addr   = ad;
  assign bus_a.datain = din;
  assign bus_b.datain = din;
  assign rdata = use_b ? bus_b.dataout : bus_a.dataout;

  fpu_param #(.EXP_W(8), .FRAC_W(23)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  fpu_param #(.EXP_W(5), .FRAC_W(10)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wr_bus(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; ad = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_bus(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1; ad = a;
    @(negedge clk);
    d = rdata;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic rd_res(input int unsigned n, output logic [31:0] v);
    logic [7:0] b;
    v = '0;
    for (int unsigned k = 0; k < n; k++) begin
      rd_bus(2'b01, b);
      v = {v[23:0], b};
    end
  endtask

  task automatic load(input logic [31:0] y, input logic [31:0] x, input int unsigned nb);
    wr_bus(2'b10, 8'd1);
    for (int unsigned k = 0; k < nb; k++) wr_bus(2'b11, y[8*(nb-1-k) +: 8]);
    wr_bus(2'b10, 8'd2);
    for (int unsigned k = 0; k < nb; k++) wr_bus(2'b11, x[8*(nb-1-k) +: 8]);
  endtask

  // Issues a command, then counts cycles with busy=1; st is the first non-busy status.
  task automatic run_op(input logic [7:0] code, output int cyc, output logic [7:0] st);
    wr_bus(2'b10, code);
    cs = 1'b1; rd = 1'b1; ad = 2'b00;
    cyc = 0;
    st  = 8'hEE;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      st = rdata;
      if (!rdata[7]) break;
      cyc++;
    end
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; ad = 2'b00; din = 8'h00; use_b = 1'b0;
    #2;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_idle_dataout got %h want 00", rdata); end
    cs = 1'b1; rd = 1'b1; ad = 2'b00; #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", rdata); end
    ad = 2'b01; #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", rdata); end
    cs = 1'b0; rd = 1'b0;
    #18 rst_n = 1'b1;
    rd_bus(2'b00, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL post_reset_status got %h want 00", b); end
  endtask

  task automatic test_divide();
    int cyc; logic [7:0] st; logic [31:0] v;
    load(32'h40C00000, 32'h40000000, 4);
    run_op(8'd3, cyc, st);
    checks++; if (cyc != 27) begin errors++; $display("FAIL div_latency got %0d want 27", cyc); end
    checks++; if (st !== 8'h40) begin errors++; $display("FAIL div_status got %h want 40", st); end
    rd_res(4, v);
    checks++; if (v !== 32'h40400000) begin errors++; $display("FAIL div_6_2 got %h want 40400000", v); end
  endtask

  task automatic test_multiply();
    int cyc; logic [7:0] st; logic [31:0] v;
    run_op(8'd4, cyc, st);
    checks++; if (cyc != 27) begin errors++; $display("FAIL mul_latency got %0d want 27", cyc); end
    rd_res(4, v);
    checks++; if (v !== 32'h41400000) begin errors++; $display("FAIL mul_6_2 got %h want 41400000", v); end
    load(32'h3FC00000, 32'h3FC00000, 4);
    run_op(8'd4, cyc, st);
    checks++; if (st !== 8'h40) begin errors++; $display("FAIL mul_norm_status got %h want 40", st); end
    rd_res(4, v);
    checks++; if (v !== 32'h40100000) begin errors++; $display("FAIL mul_1p5_sq got %h want 40100000", v); end
  endtask

  task automatic test_round();
    int cyc; logic [7:0] st; logic [31:0] v;
    load(32'h3F800000, 32'h40400000, 4);
    run_op(8'd3, cyc, st);
    checks++; if (cyc != 27) begin errors++; $display("FAIL rnd_latency got %0d want 27", cyc); end
    rd_res(4, v);
    checks++; if (v !== 32'h3EAAAAAB) begin errors++; $display("FAIL div_1_3 got %h want 3eaaaaab", v); end
  endtask

  task automatic test_abort();
    int cyc; logic [7:0] st; logic [31:0] v;
    load(32'h40C00000, 32'h40000000, 4);
    wr_bus(2'b10, 8'd3);
    repeat (7) @(posedge clk);
    #1; cs = 1'b1; rd = 1'b1; ad = 2'b00;
    @(negedge clk);
    checks++; if (rdata !== 8'h80) begin errors++; $display("FAIL abort_busy_c8 got %h want 80", rdata); end
    @(posedge clk); #1; cs = 1'b0; rd = 1'b0;
    wr_bus(2'b10, 8'd5);
    cs = 1'b1; rd = 1'b1; ad = 2'b00;
    @(negedge clk);
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL abort_status_c11 got %h want 00", rdata); end
    @(posedge clk); #1; cs = 1'b0; rd = 1'b0;
    rd_res(4, v);
    checks++; if (v !== 32'h3EAAAAAB) begin errors++; $display("FAIL abort_res_kept got %h want 3eaaaaab", v); end
    run_op(8'd3, cyc, st);
    checks++; if (cyc != 27) begin errors++; $display("FAIL restart_latency got %0d want 27", cyc); end
    checks++; if (st !== 8'h40) begin errors++; $display("FAIL restart_status got %h want 40", st); end
    rd_res(4, v);
    checks++; if (v !== 32'h40400000) begin errors++; $display("FAIL restart_res got %h want 40400000", v); end
  endtask

  task automatic test_div_zero();
    int cyc; logic [7:0] st; logic [31:0] v; logic [7:0] b;
    load(32'h3F800000, 32'h00000000, 4);
    wr_bus(2'b11, 8'hFF);
    run_op(8'd3, cyc, st);
    checks++; if (cyc != 27) begin errors++; $display("FAIL dz_latency got %0d want 27", cyc); end
    rd_res(4, v);
`ifdef FPU_EXCEPT_EN
    checks++; if (st !== 8'h60) begin errors++; $display("FAIL dz_status got %h want 60", st); end
    checks++; if (v !== 32'h7F800000) begin errors++; $display("FAIL dz_res got %h want 7f800000", v); end
`else
    checks++; if (st !== 8'h40) begin errors++; $display("FAIL dz_status got %h want 40", st); end
    checks++; if (v !== 32'h7F000000) begin errors++; $display("FAIL dz_res got %h want 7f000000", v); end
`endif
    wr_bus(2'b10, 8'd6);
    rd_bus(2'b00, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL clear_flags got %h want 00", b); end
  endtask

  task automatic test_reset_mid();
    load(32'h40C00000, 32'h40000000, 4);
    wr_bus(2'b10, 8'd4);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    cs = 1'b1; rd = 1'b1; ad = 2'b00; #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midreset_status got %h want 00", rdata); end
    ad = 2'b01; #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midreset_res got %h want 00", rdata); end
    cs = 1'b0; rd = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_small_format();
    int cyc; logic [7:0] st; logic [31:0] v;
    use_b = 1'b1;
    load(32'h00004200, 32'h00004000, 2);
    run_op(8'd4, cyc, st);
    checks++; if (cyc != 14) begin errors++; $display("FAIL small_latency got %0d want 14", cyc); end
    checks++; if (st !== 8'h40) begin errors++; $display("FAIL small_status got %h want 40", st); end
    rd_res(3, v);
    checks++; if (v !== 32'h00460046) begin errors++; $display("FAIL small_wrap got %h want 00460046", v); end
    use_b = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_divide();
    test_multiply();
    test_round();
    test_abort();
    test_div_zero();
    test_reset_mid();
    test_small_format();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
